frame_ram_arbiter: RTL

//  Shares one read-only frame RAM (ram19200x3_c, 160x120, 3-bit pixels) between NREQ pixel-scan requesters
//  (top/bottom mapper, left scanner, right scanner), so the scanners can run concurrently without private RAM copies.

---
 rtl/frame_ram_arbiter_if.sv | 31 +++
 rtl/frame_ram_arbiter.sv | 125 ++++++++++++
 2 files changed

// File: rtl/frame_ram_arbiter_if.sv
// Request/grant/RAM bus between frame_ram_arbiter (slave) and its requesters + frame RAM (master).
// The per-requester lock vector exists only when FRAME_ARB_LOCK_EN is defined.
interface frame_ram_arbiter_if #(
    parameter int NREQ   = 3,
    parameter int XSZ    = 8,
    parameter int YSZ    = 7,
    parameter int ADDRSZ = 15,
    parameter int COLSZ  = 3
);
    logic [NREQ-1:0]     req;
    logic [NREQ*XSZ-1:0] x_in;
    logic [NREQ*YSZ-1:0] y_in;
    logic [NREQ-1:0]     gnt;
    logic [ADDRSZ-1:0]   mem_address;
    logic [COLSZ-1:0]    mem_q;
    logic [NREQ-1:0]     rd_valid;
    logic [COLSZ-1:0]    pix_out;
`ifdef FRAME_ARB_LOCK_EN
    logic [NREQ-1:0]     lock;

    modport slave  (input  req, x_in, y_in, mem_q, lock,
                    output gnt, mem_address, rd_valid, pix_out);
    modport master (output req, x_in, y_in, mem_q, lock,
                    input  gnt, mem_address, rd_valid, pix_out);
`else
    modport slave  (input  req, x_in, y_in, mem_q,
                    output gnt, mem_address, rd_valid, pix_out);
    modport master (output req, x_in, y_in, mem_q,
                    input  gnt, mem_address, rd_valid, pix_out);
`endif
endinterface

// File: rtl/frame_ram_arbiter.sv
// Round-robin arbiter sharing one read-only 160x120 frame RAM between NREQ pixel scanners.
// Optional burst locking is compiled in with FRAME_ARB_LOCK_EN.
//
// state  | meaning
// IDLE   | no requests seen last cycle
// BUSY   | requests being arbitrated round-robin
// LOCKED | lock owner holds the RAM exclusively (FRAME_ARB_LOCK_EN only)
module frame_ram_arbiter #(
    parameter int NREQ   = 3,
    parameter int XSZ    = 8,
    parameter int YSZ    = 7,
    parameter int ADDRSZ = 15,
    parameter int COLSZ  = 3,
    parameter int XRES   = 160,
    parameter int YRES   = 120
) (
    input  logic                clk,
    input  logic                reset,
    frame_ram_arbiter_if.slave  bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

`ifdef FRAME_ARB_LOCK_EN
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, LOCKED = 2'd2} state_t;
    logic [PW-1:0] lock_owner_q, lock_owner_d;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1} state_t;
`endif

    state_t            state_q, state_d;
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0]   rd_valid_q;
    logic              oob_q, oob_d;

    logic              arb_found, grant, hold_ptr, oob;
    logic [PW-1:0]     arb_win, win;
    logic [XSZ-1:0]    x_sel;
    logic [YSZ-1:0]    y_sel;
    logic [ADDRSZ-1:0] addr;

    // First active requester at or after rr_ptr, wrapping at NREQ.
    always_comb begin
        arb_found = 1'b0;
        arb_win   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!arb_found && bus.req[(int'(rr_ptr_q) + k) % NREQ]) begin
                arb_found = 1'b1;
                arb_win   = PW'((int'(rr_ptr_q) + k) % NREQ);
            end
        end
    end

    always_comb begin
        grant    = arb_found;
        win      = arb_win;
        hold_ptr = 1'b0;
`ifdef FRAME_ARB_LOCK_EN
        lock_owner_d = lock_owner_q;
        if (state_q == LOCKED && bus.req[lock_owner_q] && bus.lock[lock_owner_q]) begin
            grant    = 1'b1;
            win      = lock_owner_q;
            hold_ptr = 1'b1;
        end
`endif
        if (reset)
            grant = 1'b0;

        state_d = state_q;
        if (|bus.req)
            state_d = BUSY;
        else
            state_d = IDLE;
`ifdef FRAME_ARB_LOCK_EN
        if (hold_ptr) begin
            state_d = LOCKED;
        end else if (grant && bus.lock[win]) begin
            state_d      = LOCKED;
            lock_owner_d = win;
        end
`endif

        rr_ptr_d = rr_ptr_q;
        if (grant && !hold_ptr)
            rr_ptr_d = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
    end

    // Address of the granted requester; y*160 is built from shifts when the width allows it.
    always_comb begin
        x_sel = bus.x_in[int'(win)*XSZ +: XSZ];
        y_sel = bus.y_in[int'(win)*YSZ +: YSZ];
        oob   = (int'(x_sel) >= XRES) || (int'(y_sel) >= YRES);
        if (XRES == 160)
            addr = (ADDRSZ'(y_sel) << 7) + (ADDRSZ'(y_sel) << 5) + ADDRSZ'(x_sel);
        else
            addr = ADDRSZ'(y_sel) * ADDRSZ'(XRES) + ADDRSZ'(x_sel);
        oob_d           = grant && oob;
        bus.mem_address = (grant && !oob) ? addr : '0;
        bus.gnt         = grant ? (NREQ'(1) << win) : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            rd_valid_q   <= '0;
            oob_q        <= 1'b0;
`ifdef FRAME_ARB_LOCK_EN
            lock_owner_q <= '0;
`endif
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            rd_valid_q   <= bus.gnt;
            oob_q        <= oob_d;
`ifdef FRAME_ARB_LOCK_EN
            lock_owner_q <= lock_owner_d;
`endif
        end
    end

    // Out-of-range reads return black so edge scanners stop at the frame border.
    assign bus.rd_valid = rd_valid_q;
    assign bus.pix_out  = (|rd_valid_q && !oob_q) ? bus.mem_q : '0;

endmodule
